// File: rtl/enet_pkg.sv
// Shared Ethernet MII definitions: line constants, CRC-32 parameters,
// transmit framer state encoding and a nibble-serial CRC step.
package enet_pkg;

    localparam logic [3:0]  PREAMBLE_NIB    = 4'h5;
    localparam logic [3:0]  SFD_NIB         = 4'hD;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAD,
        FCS,
        ABORT,
        DRAIN,
        IPG
    } tx_state_t;

    // Reflected CRC-32 advanced by one nibble, LSB of the nibble first.
    function automatic logic [31:0] crc32_nib(
        input logic [31:0] crc,
        input logic [3:0]  nib
    );
        logic [31:0] c;
        c = crc ^ {28'd0, nib};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/enet_mii_tx_crc.sv
// Nibble-serial reflected CRC-32 register for the MII transmit path.
// init_i has priority over en_i.
module enet_mii_tx_crc
    import enet_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [3:0]  nib_i,
    output logic [31:0] crc_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_o <= CRC32_INIT;
        end else if (init_i) begin
            crc_o <= CRC32_INIT;
        end else if (en_i) begin
            crc_o <= crc32_nib(crc_o, nib_i);
        end
    end

endmodule

// File: rtl/enet_mii_tx_framer.sv
// MII transmit framer: pops {last,byte} from the CDC FIFO and emits
// preamble, SFD, data, pad, FCS and inter-packet gap as registered nibbles.
module enet_mii_tx_framer
    import enet_pkg::*;
#(
    parameter int IPG_BYTES = 12,
    parameter int PAD_EN    = 1,
    parameter int MIN_BYTES = 60
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [8:0] fifo_data_i,
    input  logic       fifo_empty_i,
    output logic       fifo_pop_o,
    output logic [3:0] mii_txd_o,
    output logic       mii_tx_en_o,
    output logic       mii_tx_er_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       underrun_o
);

    localparam logic [11:0] MIN_CNT  = 12'(MIN_BYTES);
    localparam logic [15:0] IPG_LAST = 16'(2 * IPG_BYTES - 1);

    tx_state_t   state;
    tx_state_t   nxt;
    logic        phase;
    logic [3:0]  nib_cnt;
    logic [10:0] byte_cnt;
    logic [15:0] ipg_cnt;
    logic [7:0]  byte_q;
    logic        last_q;

    logic        pop;
    logic        crc_init;
    logic        crc_en;
    logic [3:0]  crc_nib;
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [11:0] cnt_p1;
    logic        pad_need;
    logic        in_byte;
    logic        stay_byte;

    logic [3:0]  o_txd;
    logic        o_en;
    logic        o_er;
    logic        o_done;
    logic        o_und;

    enet_mii_tx_crc u_crc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .init_i (crc_init),
        .en_i   (crc_en),
        .nib_i  (crc_nib),
        .crc_o  (crc)
    );

    assign fcs       = ~crc;
    assign cnt_p1    = {1'b0, byte_cnt} + 12'd1;
    assign pad_need  = (PAD_EN != 0) && (cnt_p1 < MIN_CNT);
    assign in_byte   = (state == DATA) || (state == PAD);
    assign stay_byte = in_byte && ((nxt == DATA) || (nxt == PAD));

    // Outputs are computed from the current state and registered, so
    // the line lags the state by one cycle. The underrun cycle is the
    // exception: it registers the abort nibble while moving to ABORT,
    // so the error nibble is on the line exactly while state is ABORT.
    always_comb begin
        nxt      = state;
        pop      = 1'b0;
        crc_init = 1'b0;
        crc_en   = 1'b0;
        crc_nib  = 4'h0;
        o_txd    = 4'h0;
        o_en     = 1'b0;
        o_er     = 1'b0;
        o_done   = 1'b0;
        o_und    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty_i) begin
                    nxt      = PRE;
                    crc_init = 1'b1;
                end
            end
            PRE: begin
                o_en  = 1'b1;
                o_txd = (nib_cnt == 4'd15) ? SFD_NIB : PREAMBLE_NIB;
                if (nib_cnt == 4'd15) begin
                    nxt = DATA;
                end
            end
            DATA: begin
                if (!phase) begin
                    if (fifo_empty_i) begin
                        nxt   = ABORT;
                        o_en  = 1'b1;
                        o_er  = 1'b1;
                        o_und = 1'b1;
                    end else begin
                        o_en    = 1'b1;
                        o_txd   = fifo_data_i[3:0];
                        crc_en  = 1'b1;
                        crc_nib = fifo_data_i[3:0];
                    end
                end else begin
                    o_en    = 1'b1;
                    o_txd   = byte_q[7:4];
                    crc_en  = 1'b1;
                    crc_nib = byte_q[7:4];
                    pop     = !fifo_empty_i;
                    if (last_q) begin
                        nxt = pad_need ? PAD : FCS;
                    end
                end
            end
            PAD: begin
                o_en   = 1'b1;
                crc_en = 1'b1;
                if (phase && (cnt_p1 >= MIN_CNT)) begin
                    nxt = FCS;
                end
            end
            FCS: begin
                o_en  = 1'b1;
                o_txd = fcs[{nib_cnt[2:0], 2'b00} +: 4];
                if (nib_cnt[2:0] == 3'd7) begin
                    o_done = 1'b1;
                    nxt    = IPG;
                end
            end
            ABORT: begin
                nxt = DRAIN;
            end
            DRAIN: begin
                if (!fifo_empty_i) begin
                    pop = 1'b1;
                    if (fifo_data_i[8]) begin
                        nxt = IPG;
                    end
                end
            end
            IPG: begin
                if (ipg_cnt == IPG_LAST) begin
                    nxt = IDLE;
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            phase        <= 1'b0;
            nib_cnt      <= 4'd0;
            byte_cnt     <= 11'd0;
            ipg_cnt      <= 16'd0;
            byte_q       <= 8'h00;
            last_q       <= 1'b0;
            mii_txd_o    <= 4'h0;
            mii_tx_en_o  <= 1'b0;
            mii_tx_er_o  <= 1'b0;
            frame_done_o <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            state   <= nxt;
            phase   <= stay_byte ? ~phase : 1'b0;
            ipg_cnt <= (state == IPG) ? ipg_cnt + 16'd1 : 16'd0;
            if (((state == PRE) || (state == FCS)) && (nxt == state)) begin
                nib_cnt <= nib_cnt + 4'd1;
            end else begin
                nib_cnt <= 4'd0;
            end
            if (crc_init) begin
                byte_cnt <= 11'd0;
            end else if (in_byte && phase && (byte_cnt != 11'h7FF)) begin
                byte_cnt <= byte_cnt + 11'd1;
            end
            if ((state == DATA) && !phase && !fifo_empty_i) begin
                byte_q <= fifo_data_i[7:0];
                last_q <= fifo_data_i[8];
            end
            mii_txd_o    <= o_txd;
            mii_tx_en_o  <= o_en;
            mii_tx_er_o  <= o_er;
            frame_done_o <= o_done;
            underrun_o   <= o_und;
        end
    end

    assign fifo_pop_o = pop;
    assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_enet_mii_tx_framer.sv
// Bench for enet_mii_tx_framer: padded and unpadded instances fed from
// queue FIFOs, line nibbles compared with a byte-level frame model.
module tb_enet_mii_tx_framer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [8:0] data0 = 9'h0;
    logic [8:0] data1 = 9'h0;
    logic       empty0 = 1'b1;
    logic       empty1 = 1'b1;
    logic       pop0, pop1;
    logic [3:0] txd0, txd1;
    logic       en0, en1, er0, er1;
    logic       busy0, busy1, done0, done1, und0, und1;

    int checks = 0;
    int errors = 0;

    logic [8:0] f0[$];
    logic [8:0] f1[$];
    logic [8:0] pend0[$];
    logic [8:0] pend1[$];
    logic [7:0] frm[$];
    logic [7:0] pbytes[$];
    logic [6:0] exq[$];
    logic [6:0] cap[$];

    enet_mii_tx_framer #(
        .IPG_BYTES (12),
        .PAD_EN    (1),
        .MIN_BYTES (60)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .fifo_data_i  (data0),
        .fifo_empty_i (empty0),
        .fifo_pop_o   (pop0),
        .mii_txd_o    (txd0),
        .mii_tx_en_o  (en0),
        .mii_tx_er_o  (er0),
        .busy_o       (busy0),
        .frame_done_o (done0),
        .underrun_o   (und0)
    );

    enet_mii_tx_framer #(
        .IPG_BYTES (12),
        .PAD_EN    (0),
        .MIN_BYTES (60)
    ) dut_np (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .fifo_data_i  (data1),
        .fifo_empty_i (empty1),
        .fifo_pop_o   (pop1),
        .mii_txd_o    (txd1),
        .mii_tx_en_o  (en1),
        .mii_tx_er_o  (er1),
        .busy_o       (busy1),
        .frame_done_o (done1),
        .underrun_o   (und1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] samp(input int sel);
        if (sel != 0) return {und1, done1, er1, txd1};
        return {und0, done0, er0, txd0};
    endfunction

    function automatic logic en_of(input int sel);
        return (sel != 0) ? en1 : en0;
    endfunction

    // FIFO models: all changes happen just after the rising edge.
    initial begin
        bit p0, p1;
        logic [8:0] tmp;
        forever begin
            @(negedge clk);
            p0 = pop0 && !empty0;
            p1 = pop1 && !empty1;
            @(posedge clk);
            #1;
            if (p0) tmp = f0.pop_front();
            if (p1) tmp = f1.pop_front();
            while (pend0.size() > 0) f0.push_back(pend0.pop_front());
            while (pend1.size() > 0) f1.push_back(pend1.pop_front());
            empty0 = (f0.size() == 0);
            empty1 = (f1.size() == 0);
            data0 = empty0 ? 9'h0 : f0[0];
            data1 = empty1 ? 9'h0 : f1[0];
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("pop_while_empty0", {31'd0, pop0 & empty0}, 32'd0);
            chk("pop_while_empty1", {31'd0, pop1 & empty1}, 32'd0);
            if (er0) chk("tx_er_without_en0", {31'd0, en0}, 32'd1);
            if (er1) chk("tx_er_without_en1", {31'd0, en1}, 32'd1);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic rand_frame(input int n);
        frm.delete();
        repeat (n) frm.push_back(8'($urandom_range(255, 0)));
    endtask

    task automatic send(input int sel, input bit mark_last);
        logic [8:0] e;
        foreach (frm[i]) begin
            e = {mark_last && (i == frm.size() - 1), frm[i]};
            if (sel != 0) pend1.push_back(e);
            else pend0.push_back(e);
        end
    endtask

    task automatic build_body(input bit pad);
        pbytes = frm;
        if (pad) while (pbytes.size() < 60) pbytes.push_back(8'h00);
        exq.delete();
        repeat (15) exq.push_back(7'h05);
        exq.push_back(7'h0D);
        foreach (pbytes[i]) begin
            exq.push_back({3'b000, pbytes[i][3:0]});
            exq.push_back({3'b000, pbytes[i][7:4]});
        end
    endtask

    task automatic build_exp(input bit pad);
        logic [31:0] c;
        build_body(pad);
        c = 32'hFFFFFFFF;
        foreach (pbytes[i]) begin
            c = c ^ {24'd0, pbytes[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 8; k++)
            exq.push_back({(k == 7) ? 3'b010 : 3'b000, c[4*k +: 4]});
    endtask

    task automatic get_frame(input int sel, output int gap);
        gap = 0;
        cap.delete();
        forever begin
            @(negedge clk);
            if (en_of(sel)) break;
            gap++;
            if (gap > 300) begin
                chk("frame_start_timeout", {31'd0, en_of(sel)}, 32'd1);
                return;
            end
        end
        while (en_of(sel) && cap.size() < 2000) begin
            cap.push_back(samp(sel));
            @(negedge clk);
        end
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, " length"}, cap.size(), exq.size());
        n = (cap.size() < exq.size()) ? cap.size() : exq.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s nib%0d", tag, i), {25'd0, cap[i]}, {25'd0, exq[i]});
    endtask

    initial begin
        int gap;
        int n;
        logic [6:0] ex_a[$];
        logic [6:0] ex_b[$];
        logic [3:0] fcs1[8];

        repeat (3) @(negedge clk);
        chk("rst txd", {28'd0, txd0}, 32'd0);
        chk("rst tx_en", {31'd0, en0}, 32'd0);
        chk("rst tx_er", {31'd0, er0}, 32'd0);
        chk("rst busy", {31'd0, busy0}, 32'd0);
        chk("rst pop", {31'd0, pop0}, 32'd0);
        chk("rst done", {31'd0, done0}, 32'd0);
        chk("rst underrun", {31'd0, und0}, 32'd0);
        chk("rst np tx_en", {31'd0, en1}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", {31'd0, busy0}, 32'd0);
        chk("idle tx_en", {31'd0, en0}, 32'd0);

        // "123456789" without padding, FCS against the known check value
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        send(1, 1'b1);
        build_body(1'b0);
        fcs1 = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
        for (int k = 0; k < 8; k++)
            exq.push_back({(k == 7) ? 3'b010 : 3'b000, fcs1[k]});
        get_frame(1, gap);
        compare("t1 check string");

        // 14-byte frame padded to 60
        rand_frame(14);
        send(0, 1'b1);
        build_exp(1'b1);
        get_frame(0, gap);
        compare("t2 padded");
        chk("t2 nibble total", cap.size(), 32'd144);

        // two 64-byte frames back-to-back
        rand_frame(64);
        send(0, 1'b1);
        build_exp(1'b1);
        ex_a = exq;
        rand_frame(64);
        send(0, 1'b1);
        build_exp(1'b1);
        ex_b = exq;
        get_frame(0, gap);
        exq = ex_a;
        compare("t3 frame a");
        get_frame(0, gap);
        chk("t3 ipg cycles", gap + 1, 32'd25);
        exq = ex_b;
        compare("t3 frame b");

        // underrun after byte 5 of 20
        rand_frame(5);
        send(0, 1'b0);
        build_body(1'b0);
        exq.push_back(7'h50);
        get_frame(0, gap);
        compare("t4 abort");
        rand_frame(15);
        send(0, 1'b1);
        repeat (60) begin
            @(negedge clk);
            chk("t4 drain tx_en", {31'd0, en0}, 32'd0);
        end
        chk("t4 fifo drained", f0.size(), 32'd0);
        chk("t4 idle after ipg", {31'd0, busy0}, 32'd0);
        rand_frame(30);
        send(0, 1'b1);
        build_exp(1'b1);
        get_frame(0, gap);
        compare("t4 next frame");

        // reset during the third FCS nibble
        rand_frame(10);
        send(0, 1'b1);
        build_exp(1'b1);
        n = 0;
        while (!en0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t5 frame start", {31'd0, en0}, 32'd1);
        repeat (138) @(negedge clk);
        chk("t5 en before reset", {31'd0, en0}, 32'd1);
        chk("t5 fcs nib3", {28'd0, txd0}, {28'd0, exq[138][3:0]});
        rst_n = 1'b0;
        #1;
        chk("t5 async txd", {28'd0, txd0}, 32'd0);
        chk("t5 async tx_en", {31'd0, en0}, 32'd0);
        chk("t5 async tx_er", {31'd0, er0}, 32'd0);
        chk("t5 async done", {31'd0, done0}, 32'd0);
        chk("t5 async busy", {31'd0, busy0}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5 idle busy", {31'd0, busy0}, 32'd0);
        chk("t5 idle tx_en", {31'd0, en0}, 32'd0);
        chk("t5 fifo empty", f0.size(), 32'd0);
        rand_frame(20);
        send(0, 1'b1);
        build_exp(1'b1);
        get_frame(0, gap);
        compare("t5 fresh frame");

        // single byte 0xAB with padding
        frm.delete();
        frm.push_back(8'hAB);
        send(0, 1'b1);
        build_exp(1'b1);
        get_frame(0, gap);
        compare("t6 one byte");

        for (int r = 0; r < 6; r++) begin
            rand_frame(int'($urandom_range(80, 1)));
            send(0, 1'b1);
            build_exp(1'b1);
            get_frame(0, gap);
            compare($sformatf("rnd pad %0d", r));
        end
        for (int r = 0; r < 2; r++) begin
            rand_frame(int'($urandom_range(40, 1)));
            send(1, 1'b1);
            build_exp(1'b0);
            get_frame(1, gap);
            compare($sformatf("rnd nopad %0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
